wallace_mac: RTL and testbench

- Sequential multiply-accumulate stage that feeds the existing combinational 4x4 Wallace tree multiplier and consumes its 8-bit product.
- Accepts a stream of unsigned 4-bit operand pairs over a valid/ready handshake.
- Sums LEN consecutive products into one dot-product result and presents it over a second valid/ready handshake.

---
 rtl/wallace_mac_pkg.sv | 19 +
 rtl/wallace_mac_if.sv | 39 +++
 rtl/wallace_mac_mult.sv | 30 +++
 rtl/wallace_mac.sv | 108 ++++++++++
 tb/tb_wallace_mac.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/wallace_mac_pkg.sv
// Shared widths, FSM state type and accumulator sizing rule for the Wallace MAC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wallace_mac_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Smallest accumulator that can hold len full-scale products without wrapping.
    function automatic int min_acc_w(input int len);
        return PROD_W + $clog2(len);
    endfunction

endpackage

// File: rtl/wallace_mac_if.sv
// Operand-in / dot-product-out handshake bundle for wallace_mac.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid-ready stalls.
interface wallace_mac_if #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) ();
    import wallace_mac_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [OP_W-1:0]            a;
    logic [OP_W-1:0]            b;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           acc;
    logic [$clog2(LEN+1)-1:0]   cnt;
`ifdef WALLACE_MAC_PEAK_EN
    logic [PROD_W-1:0]          peak;
`endif

    // master: operand source and result sink; slave: the MAC itself.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc, cnt
`ifdef WALLACE_MAC_PEAK_EN
        , input peak
`endif
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, acc, cnt
`ifdef WALLACE_MAC_PEAK_EN
        , output peak
`endif
    );

endinterface

// File: rtl/wallace_mac_mult.sv
// Combinational 4x4 unsigned Wallace tree multiplier (two 3:2 CSA layers + final add).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module WallaceTreeMult (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] pp [4];
    logic [7:0] s1, c1, s2, c2, maj1, maj2;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = {4'b0000, a & {4{b[i]}}} << i;
        end
    end

    // Carries out of bit 7 are dropped safely: the product never exceeds 225.
    assign s1   = pp[0] ^ pp[1] ^ pp[2];
    assign maj1 = (pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2]);
    assign c1   = {maj1[6:0], 1'b0};

    assign s2   = s1 ^ c1 ^ pp[3];
    assign maj2 = (s1 & c1) | (s1 & pp[3]) | (c1 & pp[3]);
    assign c2   = {maj2[6:0], 1'b0};

    assign p = s2 + c2;

endmodule

// File: rtl/wallace_mac.sv
// Dot-product MAC: sums LEN Wallace products; optional peak output under WALLACE_MAC_PEAK_EN.
// Latency: result valid 2 edges after the final pair is accepted (1 capture + 1 accumulate).
// Backpressure: HOLD freezes the result and drops in_ready until out_ready handshakes.
module wallace_mac
    import wallace_mac_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    wallace_mac_if.slave bus
);

    localparam int CNT_W = $clog2(LEN + 1);

    generate
        if (LEN < 1) begin : g_bad_len
            $error("wallace_mac: LEN must be >= 1");
        end
        if (ACC_W < min_acc_w(LEN)) begin : g_bad_acc_w
            $error("wallace_mac: ACC_W too narrow for LEN");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_a_q, op_b_q;
    logic               op_v_q;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   accepted_q;
    logic               accept;
    logic               last_prod;
    logic               release_res;

    WallaceTreeMult u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

    assign bus.in_ready  = !rst && (state_q == ACCUM) && (accepted_q < CNT_W'(LEN));
    assign bus.out_valid = !rst && (state_q == HOLD);
    assign bus.acc       = acc_q;
    assign bus.cnt       = cnt_q;

    assign accept      = bus.in_valid && bus.in_ready;
    assign last_prod   = op_v_q && (cnt_q == CNT_W'(LEN - 1));
    assign release_res = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (last_prod)   state_d = HOLD;
            HOLD:    if (release_res) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // No pair can be accepted in HOLD, so release never collides with accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_v_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            accepted_q <= '0;
        end else if (release_res) begin
            op_v_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            accepted_q <= '0;
        end else begin
            op_v_q <= accept;
            if (accept) begin
                op_a_q     <= bus.a;
                op_b_q     <= bus.b;
                accepted_q <= accepted_q + CNT_W'(1);
            end
            if (op_v_q) begin
                acc_q <= acc_q + ACC_W'(prod);
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef WALLACE_MAC_PEAK_EN
    logic [PROD_W-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (rst || release_res) begin
            peak_q <= '0;
        end else if (op_v_q && (prod > peak_q)) begin
            peak_q <= prod;
        end
    end

    assign bus.peak = peak_q;
`endif

endmodule

// File: tb/tb_wallace_mac.sv
// Directed bench for wallace_mac: operand pairs feed a scoreboard queue of expected dot products.
module tb_wallace_mac;

    localparam int LEN   = 4;
    localparam int ACC_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    int unsigned exp_q [$];
    int unsigned model_sum = 0;
    int          model_n   = 0;

    wallace_mac_if #(.LEN(LEN), .ACC_W(ACC_W)) bus ();

    wallace_mac #(.LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one pair, wait (bounded) for in_ready, consume it at the next edge, then idle gap cycles.
    task automatic send(input logic [3:0] x, input logic [3:0] y, input int gap);
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        for (int k = 0; k < 40 && !bus.in_ready; k++) step();
        check("send_rdy", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        model_sum += x * y;
        model_n++;
        if (model_n == LEN) begin
            exp_q.push_back(model_sum);
            model_sum = 0;
            model_n   = 0;
        end
        repeat (gap) step();
    endtask

    // Wait (bounded) for out_valid and compare acc against the oldest scoreboard entry.
    task automatic collect(input string tag);
        int unsigned exp_acc;
        for (int k = 0; k < 40 && !bus.out_valid; k++) step();
        check({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sb observed=result expected=no_result_pending", tag);
        end else begin
            exp_acc = exp_q.pop_front();
            check({tag, "_acc"}, 32'(bus.acc), exp_acc);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset
        step();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_acc", 32'(bus.acc), 32'd0);
        check("post_rst_cnt", 32'(bus.cnt), 32'd0);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back vector, result exactly one cycle
        send(4'd11, 4'd10, 0);
        send(4'd15, 4'd15, 0);
        send(4'd10, 4'd14, 0);
        send(4'd9,  4'd8,  0);
        check("t1_not_early", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("t1_vld_edge", {31'd0, bus.out_valid}, 32'd1);
        collect("t1");
        check("t1_cnt", 32'(bus.cnt), 32'd4);
        check("t1_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
`ifdef WALLACE_MAC_PEAK_EN
        check("t1_peak", 32'(bus.peak), 32'd225);
`endif
        step();
        check("t1_vld_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        check("t1_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("t1_acc_cleared", 32'(bus.acc), 32'd0);
        check("t1_cnt_cleared", 32'(bus.cnt), 32'd0);
`ifdef WALLACE_MAC_PEAK_EN
        check("t1_peak_cleared", 32'(bus.peak), 32'd0);
`endif

        // Bubbles between pairs
        send(4'd8, 4'd0,  1);
        send(4'd1, 4'd12, 2);
        send(4'd0, 4'd0,  3);
        send(4'd2, 4'd14, 0);
        collect("t2");
        check("t2_cnt", 32'(bus.cnt), 32'd4);
        step();

        // Full-scale operands
        send(4'd15, 4'd15, 0);
        send(4'd15, 4'd15, 0);
        send(4'd15, 4'd15, 0);
        send(4'd15, 4'd15, 0);
        check("t3_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        collect("t3");
        step();

        // Backpressure: result held, no accepts
        bus.out_ready = 1'b0;
        send(4'd11, 4'd10, 0);
        send(4'd15, 4'd15, 0);
        send(4'd10, 4'd14, 0);
        send(4'd9,  4'd8,  0);
        collect("t4");
        bus.in_valid = 1'b1;
        bus.a        = 4'd3;
        bus.b        = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_acc", 32'(bus.acc), 32'd547);
            check("t4_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("t4_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        check("t4_hold_cnt", 32'(bus.cnt), 32'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("t4_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) send(4'd3, 4'd3, 0);
        collect("t4b");
        step();

        // Reset mid-vector discards the partial sum
        send(4'd5, 4'd5, 0);
        send(4'd6, 4'd6, 0);
        model_sum = 0;
        model_n   = 0;
        rst = 1'b1;
        step();
        check("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t5_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("t5_acc_zero", 32'(bus.acc), 32'd0);
        check("t5_cnt_zero", 32'(bus.cnt), 32'd0);
        send(4'd3, 4'd11, 0);
        send(4'd7, 4'd9,  0);
        send(4'd1, 4'd1,  0);
        send(4'd2, 4'd2,  0);
        collect("t5");
        step();
        check("t5_done_out_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
